// File: rtl/mac_pkg.sv
// Types shared by the squared-accumulate MAC and its output stage.
package mac_pkg;

  localparam int ACC_W = 20;

  typedef logic [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic ovf;
    acc_t f;
  } mac_entry_t;

endpackage

// File: rtl/mac_out_fifo_if.sv
// Sample capture and consumer handshake between the MAC, the output FIFO and its consumer.
interface mac_out_fifo_if #(
  parameter int WIDTH = 20
);

  logic             valid_in;
  logic [WIDTH-1:0] f_in;
  logic             ready_in;
  logic             valid_out;
  logic [WIDTH-1:0] f_out;
  logic             ovf_out;

  modport master (
    output valid_in, f_in, ready_in,
    input  valid_out, f_out, ovf_out
  );

  modport slave (
    input  valid_in, f_in, ready_in,
    output valid_out, f_out, ovf_out
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrap-bit pointers, occupancy and push/pop arbitration.
module sync_fifo #(
  parameter int DW    = 21,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_req,
  input  logic                   pop_req,
  input  logic [DW-1:0]          wr_data,
  output logic [DW-1:0]          rd_data,
  output logic                   push_ok,
  output logic                   pop_ok,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop_req && !empty;
  assign push_ok = push_req && (!full || pop_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head is never X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_out_fifo.sv
// MAC output stage: sticky wrap tagging, buffering and saturating drop counting.
module mac_out_fifo
  import mac_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_out_fifo_if.slave          bus,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int DW = $bits(mac_entry_t);

  acc_t       last_f;
  logic       ovf_sticky;
  acc_t       last_base;
  logic       sticky_base;
  logic       wrap;
  logic       tag;
  mac_entry_t wr_entry;
  mac_entry_t rd_entry;
  logic       push_ok;
  logic       pop_ok;
  logic       empty;
  logic       drop;

  // A coincident clear restarts tracking before this sample is compared.
  always_comb begin
    last_base      = clear ? '0 : last_f;
    sticky_base    = clear ? 1'b0 : ovf_sticky;
    wrap           = (bus.f_in < last_base);
    tag            = sticky_base | wrap;
    wr_entry.ovf   = tag;
    wr_entry.f     = bus.f_in;
  end

  assign drop = bus.valid_in && !push_ok;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_req (bus.valid_in),
    .pop_req  (bus.ready_in),
    .wr_data  (wr_entry),
    .rd_data  (rd_entry),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign bus.valid_out = !empty;
  assign bus.f_out     = rd_entry.f;
  assign bus.ovf_out   = rd_entry.ovf;

  // Overflow tracker follows every sample, accepted or dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_f     <= '0;
      ovf_sticky <= 1'b0;
    end else if (bus.valid_in) begin
      last_f     <= bus.f_in;
      ovf_sticky <= tag;
    end else if (clear) begin
      last_f     <= '0;
      ovf_sticky <= 1'b0;
    end
  end

  // Saturating drop counter; clear takes priority over a same-cycle drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
